// File: rtl/ram_rf.sv
// Register-file wrapper around the 32 x 16 TestRAM: a software port with a
// two-cycle read handshake and a hardware port with single-cycle reads.
module ram_rf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int BUS_W  = 64
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic [7:3]        address,
   input  logic              read_en,
   input  logic              write_en,
   input  logic [BUS_W-1:0]  write_data,
   output logic [BUS_W-1:0]  read_data,
   output logic              invalid_address,
   output logic              access_complete,
   input  logic [4:0]        info_rf_TestRAM_addr,
   input  logic              info_rf_TestRAM_ren,
   output logic [DATA_W-1:0] info_rf_TestRAM_rdata,
   input  logic              info_rf_TestRAM_wen,
   input  logic [DATA_W-1:0] info_rf_TestRAM_wdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              sw_wr;
   logic              sw_rd;
   logic              hw_wr;
   logic              hw_rd;
   logic              vld_p0;
   logic [DATA_W-1:0] rd_data_p0;

   // Only the low DATA_W bits of the software bus are stored.
   logic unused_write_data;
   assign unused_write_data = ^write_data[BUS_W-1:DATA_W];

   function automatic logic [BUS_W-1:0] zext(input logic [DATA_W-1:0] d);
      return {{(BUS_W-DATA_W){1'b0}}, d};
   endfunction

   // A pending read blocks the software port; a write beats a same-cycle read.
   assign sw_wr = write_en && !vld_p0 && !res_n;
   assign sw_rd = read_en && !write_en && !vld_p0 && !res_n;
   assign hw_wr = info_rf_TestRAM_wen && !res_n;
   assign hw_rd = info_rf_TestRAM_ren && !res_n;

   // Storage: hardware write is applied last so it wins on a same-entry clash.
   always_ff @(posedge clk) begin
      if (sw_wr)
         mem[address] <= write_data[DATA_W-1:0];
      if (hw_wr)
         mem[info_rf_TestRAM_addr] <= info_rf_TestRAM_wdata;
   end

   // Stage p0: software read sample (pre-write contents)
   always_ff @(posedge clk) begin
      if (sw_rd)
         rd_data_p0 <= mem[address];
   end

   // Stage p1: registered software response and hardware read port
   always_ff @(posedge clk) begin
      if (res_n) begin
         vld_p0                <= 1'b0;
         read_data             <= '0;
         access_complete       <= 1'b0;
         invalid_address       <= 1'b0;
         info_rf_TestRAM_rdata <= '0;
      end else begin
         vld_p0          <= sw_rd;
         access_complete <= sw_wr || vld_p0;
         invalid_address <= 1'b0;
         if (vld_p0)
            read_data <= zext(rd_data_p0);
         if (hw_rd)
            info_rf_TestRAM_rdata <= mem[info_rf_TestRAM_addr];
      end
   end

endmodule

// File: tb/tb_ram_rf.sv
// Scoreboard bench for ram_rf: a model RAM predicts every software completion
// and hardware read; the monitor compares them on the falling edge.
module tb_ram_rf;

   logic        clk = 1'b0;
   logic        res_n;
   logic [7:3]  address;
   logic        read_en;
   logic        write_en;
   logic [63:0] write_data;
   logic [63:0] read_data;
   logic        invalid_address;
   logic        access_complete;
   logic [4:0]  hw_addr;
   logic        hw_ren;
   logic [15:0] hw_rdata;
   logic        hw_wen;
   logic [15:0] hw_wdata;

   ram_rf dut (
      .clk                   (clk),
      .res_n                 (res_n),
      .address               (address),
      .read_en               (read_en),
      .write_en              (write_en),
      .write_data            (write_data),
      .read_data             (read_data),
      .invalid_address       (invalid_address),
      .access_complete       (access_complete),
      .info_rf_TestRAM_addr  (hw_addr),
      .info_rf_TestRAM_ren   (hw_ren),
      .info_rf_TestRAM_rdata (hw_rdata),
      .info_rf_TestRAM_wen   (hw_wen),
      .info_rf_TestRAM_wdata (hw_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      int          cyc;
      logic [63:0] data;
   } sw_exp_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } hw_exp_t;

   sw_exp_t     sw_q[$];
   hw_exp_t     hw_q[$];
   logic [15:0] model [32];
   logic [63:0] last_read = '0;
   logic [15:0] last_hw = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare due expectations, flag unexpected completions.
   always @(negedge clk) begin
      if (sw_q.size() > 0 && sw_q[0].cyc == cyc) begin
         sw_exp_t e;
         e = sw_q.pop_front();
         check("sw_complete", {63'b0, access_complete}, 64'd1);
         check("sw_invalid", {63'b0, invalid_address}, 64'd0);
         if (e.rd) begin
            check("sw_read_data", read_data, e.data);
            last_read = e.data;
         end else begin
            check("sw_read_hold", read_data, last_read);
         end
      end else if (access_complete === 1'b1) begin
         check("sw_spurious_complete", 64'd1, 64'd0);
      end
      if (hw_q.size() > 0 && hw_q[0].cyc == cyc) begin
         hw_exp_t h;
         h = hw_q.pop_front();
         check("hw_read_data", {48'b0, hw_rdata}, {48'b0, h.data});
         last_hw = h.data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sw_write(input int a, input logic [63:0] d);
      address = 5'(a); write_data = d; write_en = 1'b1;
      sw_q.push_back('{rd: 1'b0, cyc: cyc + 1, data: '0});
      model[a] = d[15:0];
      tick();
      write_en = 1'b0;
   endtask

   task automatic sw_read(input int a);
      address = 5'(a); read_en = 1'b1;
      sw_q.push_back('{rd: 1'b1, cyc: cyc + 2, data: {48'b0, model[a]}});
      tick();
      read_en = 1'b0;
      tick();
   endtask

   task automatic hw_write(input int a, input logic [15:0] d);
      hw_addr = 5'(a); hw_wdata = d; hw_wen = 1'b1;
      model[a] = d;
      tick();
      hw_wen = 1'b0;
   endtask

   task automatic hw_read(input int a);
      hw_addr = 5'(a); hw_ren = 1'b1;
      hw_q.push_back('{cyc: cyc + 1, data: model[a]});
      tick();
      hw_ren = 1'b0;
   endtask

   initial begin
      logic [15:0] old;
      res_n = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
      hw_addr = '0; hw_ren = 1'b0; hw_wen = 1'b0; hw_wdata = '0;
      repeat (3) tick();
      check("rst_read_data", read_data, 64'd0);
      check("rst_complete", {63'b0, access_complete}, 64'd0);
      check("rst_invalid", {63'b0, invalid_address}, 64'd0);
      check("rst_hw_rdata", {48'b0, hw_rdata}, 64'd0);
      res_n = 1'b0;
      tick();

      // Software fill, hardware readback
      for (int k = 0; k < 32; k++) sw_write(k, 64'(k + 32));
      for (int k = 0; k < 32; k++) hw_read(k);
      repeat (3) tick();
      check("hw_rdata_hold", {48'b0, hw_rdata}, {48'b0, last_hw});

      // Hardware fill, software readback
      for (int k = 0; k < 32; k++) hw_write(k, 16'(k));
      for (int k = 0; k < 32; k++) sw_read(k);

      // Upper write_data bits are dropped
      sw_write(5, 64'hFFFF_FFFF_FFFF_1234);
      sw_read(5);

      // Same-entry write from both ports: hardware wins
      address = 5'd3; write_data = 64'h1111; write_en = 1'b1;
      hw_addr = 5'd3; hw_wdata = 16'h2222; hw_wen = 1'b1;
      sw_q.push_back('{rd: 1'b0, cyc: cyc + 1, data: '0});
      model[3] = 16'h2222;
      tick();
      write_en = 1'b0; hw_wen = 1'b0;
      sw_read(3);
      hw_read(3);

      // Read of an entry written in the same cycle returns old data
      old = model[7];
      address = 5'd7; read_en = 1'b1;
      hw_addr = 5'd7; hw_wdata = 16'hBEEF; hw_wen = 1'b1; hw_ren = 1'b1;
      sw_q.push_back('{rd: 1'b1, cyc: cyc + 2, data: {48'b0, old}});
      hw_q.push_back('{cyc: cyc + 1, data: old});
      model[7] = 16'hBEEF;
      tick();
      read_en = 1'b0; hw_wen = 1'b0; hw_ren = 1'b0;
      tick();
      sw_read(7);

      // read_en with write_en: only the write happens
      address = 5'd12; write_data = 64'h5A5A; write_en = 1'b1; read_en = 1'b1;
      sw_q.push_back('{rd: 1'b0, cyc: cyc + 1, data: '0});
      model[12] = 16'h5A5A;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      repeat (3) tick();
      sw_read(12);

      // Write during a pending read is ignored
      address = 5'd9; read_en = 1'b1;
      sw_q.push_back('{rd: 1'b1, cyc: cyc + 2, data: {48'b0, model[9]}});
      tick();
      read_en = 1'b0;
      write_en = 1'b1; write_data = 64'hDEAD;
      tick();
      write_en = 1'b0;
      tick();
      sw_read(9);

      // Reset aborts a pending read; requests during reset are ignored
      address = 5'd20; read_en = 1'b1;
      tick();
      read_en = 1'b0; res_n = 1'b1;
      write_en = 1'b1; write_data = 64'h7777;
      hw_wen = 1'b1; hw_addr = 5'd21; hw_wdata = 16'h8888;
      tick();
      write_en = 1'b0; hw_wen = 1'b0; res_n = 1'b0;
      repeat (3) tick();
      check("abort_read_data", read_data, 64'd0);
      last_read = '0;
      sw_read(20);
      hw_read(21);
      sw_read(0);
      repeat (4) tick();

      check("sw_queue_drained", 64'(sw_q.size()), 64'd0);
      check("hw_queue_drained", 64'(hw_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
